cdc_host_seq: RTL and testbench

CDC_HOST_SEQ -- requirements
Module: cdc_host_seq

---
 rtl/cdc_pkg.sv | 53 +++++
 rtl/cdc_host_seq_if.sv | 12 +
 rtl/cdc_bus_cycle.sv | 64 ++++++
 rtl/cdc_host_seq.sv | 170 +++++++++++++++++
 tb/tb_cdc_host_seq.sv | 230 +++++++++++++++++++++++
 5 files changed

// File: rtl/cdc_pkg.sv
// Shared definitions for the CD host chip sequencer: register map, IFSTAT bits, init values, states.
package cdc_pkg;

  localparam logic [7:0] REG_IFCTRL = 8'd1;
  localparam logic [7:0] REG_IFSTAT = 8'd1;
  localparam logic [7:0] REG_DBCL   = 8'd2;
  localparam logic [7:0] REG_DACL   = 8'd4;
  localparam logic [7:0] REG_HEAD0  = 8'd4;
  localparam logic [7:0] REG_DTTRG  = 8'd6;
  localparam logic [7:0] REG_DTACK  = 8'd7;
  localparam logic [7:0] REG_CTRL0  = 8'd10;
  localparam logic [7:0] REG_STAT0  = 8'd12;
  localparam logic [7:0] REG_STAT3  = 8'd15;

  // IFSTAT flags are active-low
  localparam int IFSTAT_DECI = 5;
  localparam int IFSTAT_DTEI = 6;

  localparam logic [7:0] INIT_IFCTRL = 8'h60;
  localparam logic [7:0] INIT_CTRL0  = 8'h80;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_INIT,
    ST_WAIT_IRQ,
    ST_RD_IFSTAT,
    ST_RD_HEAD,
    ST_RD_STAT,
    ST_PROG,
    ST_WAIT_DTE,
    ST_ACK
  } state_t;

  typedef struct packed {
    logic       we;
    logic       rs;
    logic [7:0] wdata;
  } acc_t;

  // Index of the final access of each multi-access state (step 0 is the address write)
  function automatic logic [2:0] last_step(input state_t s);
    case (s)
      ST_INIT:      return 3'd3;
      ST_RD_IFSTAT: return 3'd1;
      ST_RD_HEAD:   return 3'd4;
      ST_RD_STAT:   return 3'd4;
      ST_PROG:      return 3'd5;
      ST_ACK:       return 3'd1;
      default:      return 3'd0;
    endcase
  endfunction

endpackage

// File: rtl/cdc_host_seq_if.sv
// Parallel register bus to the CD host chip: register select, active-low strobes, data and interrupt.
interface cdc_host_seq_if;
  logic       rs;
  logic       nwr;
  logic       nrd;
  logic [7:0] wdata;
  logic [7:0] rdata;
  logic       nirq;

  modport master (output rs, nwr, nrd, wdata, input rdata, nirq);
  modport slave  (input rs, nwr, nrd, wdata, output rdata, nirq);
endinterface

// File: rtl/cdc_bus_cycle.sv
// Five-clock access engine: T0 setup, T1-T3 strobe low, T4 recovery; done is high during T4.
// Read data is sampled only on the edge ending T3; a new req is accepted only while idle.
module cdc_bus_cycle (
  input  logic           clk,
  input  logic           nRESET,
  input  logic           req,
  input  logic           we,
  input  logic           rs,
  input  logic [7:0]     wdata,
  output logic           done,
  output logic [7:0]     rdata,
  cdc_host_seq_if.master bus
);

  logic       active;
  logic [2:0] phase;
  logic       we_q;
  logic       rs_q;
  logic [7:0] wdata_q;
  logic       nwr_q;
  logic       nrd_q;
  logic [7:0] rdata_q;

  assign done      = active && (phase == 3'd4);
  assign rdata     = rdata_q;
  assign bus.rs    = rs_q;
  assign bus.wdata = wdata_q;
  assign bus.nwr   = nwr_q;
  assign bus.nrd   = nrd_q;

  always_ff @(posedge clk or negedge nRESET) begin
    if (!nRESET) begin
      active  <= 1'b0;
      phase   <= 3'd0;
      we_q    <= 1'b0;
      rs_q    <= 1'b0;
      wdata_q <= 8'h00;
      nwr_q   <= 1'b1;
      nrd_q   <= 1'b1;
      rdata_q <= 8'h00;
    end else begin
      if (req && !active) begin
        active  <= 1'b1;
        phase   <= 3'd0;
        we_q    <= we;
        rs_q    <= rs;
        wdata_q <= wdata;
      end else if (active) begin
        if (phase == 3'd4) active <= 1'b0;
        else               phase  <= phase + 3'd1;
      end
      if (active && (phase == 3'd0)) begin
        nwr_q <= !we_q;
        nrd_q <= we_q;
      end
      if (active && (phase == 3'd3)) begin
        nwr_q <= 1'b1;
        nrd_q <= 1'b1;
        if (!we_q) rdata_q <= bus.rdata;
      end
    end
  end

endmodule

// File: rtl/cdc_host_seq.sv
// CD host chip sequencer: init, per-sector header/status capture, transfer programming and DTE acknowledge.
// One access in flight at a time; ENABLE is honoured only between accesses.
module cdc_host_seq
  import cdc_pkg::*;
(
  input  logic           clk_12m,
  input  logic           nRESET,
  input  logic           enable,
  input  logic [11:0]    xfer_len,
  cdc_host_seq_if.master bus,
  output logic [7:0]     head_m,
  output logic [7:0]     head_s,
  output logic [7:0]     head_f,
  output logic [7:0]     head_mode,
  output logic [7:0]     stat0,
  output logic           sector_stb,
  output logic           xfer_done,
  output logic           busy
);

  state_t     state;
  state_t     state_nx;
  logic [2:0] step;
  logic [2:0] step_nx;
  logic       inflight;
  logic       acc_state;
  logic       req;
  logic       done;
  logic [7:0] rdata;
  logic [3:0] len_hi;
  logic       irq_s1;
  logic       irq_s2;
  acc_t       acc;

  cdc_bus_cycle u_bus (
    .clk    (clk_12m),
    .nRESET (nRESET),
    .req    (req),
    .we     (acc.we),
    .rs     (acc.rs),
    .wdata  (acc.wdata),
    .done   (done),
    .rdata  (rdata),
    .bus    (bus)
  );

  assign acc_state  = (state != ST_IDLE) && (state != ST_WAIT_IRQ) && (state != ST_WAIT_DTE);
  assign req        = acc_state && !inflight;
  assign busy       = (state != ST_IDLE);
  assign sector_stb = done && (state == ST_RD_STAT) && (step == last_step(ST_RD_STAT));

  // Access descriptor for the current step; data accesses rely on target auto-increment
  always_comb begin
    acc = '{we: 1'b1, rs: 1'b1, wdata: 8'h00};
    case (state)
      ST_INIT: begin
        case (step)
          3'd0:    acc = '{we: 1'b1, rs: 1'b0, wdata: REG_IFCTRL};
          3'd1:    acc.wdata = INIT_IFCTRL;
          3'd2:    acc = '{we: 1'b1, rs: 1'b0, wdata: REG_CTRL0};
          default: acc.wdata = INIT_CTRL0;
        endcase
      end
      ST_RD_IFSTAT, ST_RD_HEAD, ST_RD_STAT: begin
        acc.we    = (step == 3'd0);
        acc.rs    = (step != 3'd0);
        acc.wdata = (state == ST_RD_IFSTAT) ? REG_IFSTAT :
                    (state == ST_RD_HEAD)   ? REG_HEAD0  : REG_STAT0;
      end
      ST_PROG: begin
        case (step)
          3'd0:    begin acc.rs = 1'b0; acc.wdata = REG_DBCL; end
          3'd1:    acc.wdata = xfer_len[7:0];
          3'd2:    acc.wdata = {4'h0, len_hi};
          default: acc.wdata = 8'h00;
        endcase
      end
      ST_ACK: begin
        if (step == 3'd0) begin
          acc.rs    = 1'b0;
          acc.wdata = REG_DTACK;
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    state_nx = state;
    step_nx  = step;
    case (state)
      ST_IDLE: begin
        if (enable) begin
          state_nx = ST_INIT;
          step_nx  = 3'd0;
        end
      end
      ST_WAIT_IRQ, ST_WAIT_DTE: begin
        if (!enable) begin
          state_nx = ST_IDLE;
        end else if (!irq_s2) begin
          state_nx = ST_RD_IFSTAT;
          step_nx  = 3'd0;
        end
      end
      default: begin
        if (done) begin
          step_nx = 3'd0;
          if (!enable) begin
            state_nx = ST_IDLE;
          end else if (step != last_step(state)) begin
            step_nx = step + 3'd1;
          end else begin
            case (state)
              ST_INIT:    state_nx = ST_WAIT_IRQ;
              ST_RD_IFSTAT: begin
                // Decoder interrupt wins; a pending transfer end is seen at the next IRQ check
                if (!rdata[IFSTAT_DECI])      state_nx = ST_RD_HEAD;
                else if (!rdata[IFSTAT_DTEI]) state_nx = ST_ACK;
                else                          state_nx = ST_WAIT_IRQ;
              end
              ST_RD_HEAD: state_nx = ST_RD_STAT;
              ST_RD_STAT: state_nx = ST_PROG;
              ST_PROG:    state_nx = ST_WAIT_DTE;
              default:    state_nx = ST_WAIT_IRQ;
            endcase
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk_12m or negedge nRESET) begin
    if (!nRESET) begin
      state     <= ST_IDLE;
      step      <= 3'd0;
      inflight  <= 1'b0;
      len_hi    <= 4'h0;
      irq_s1    <= 1'b1;
      irq_s2    <= 1'b1;
      head_m    <= 8'h00;
      head_s    <= 8'h00;
      head_f    <= 8'h00;
      head_mode <= 8'h00;
      stat0     <= 8'h00;
      xfer_done <= 1'b0;
    end else begin
      state  <= state_nx;
      step   <= step_nx;
      irq_s1 <= bus.nirq;
      irq_s2 <= irq_s1;
      if (req)       inflight <= 1'b1;
      else if (done) inflight <= 1'b0;
      // Length is frozen when the low byte goes out so both bytes describe the same sector
      if (req && (state == ST_PROG) && (step == 3'd1)) len_hi <= xfer_len[11:8];
      xfer_done <= done && (state == ST_ACK) && (step == last_step(ST_ACK));
      if (done && (state == ST_RD_HEAD)) begin
        case (step)
          3'd1:    head_m    <= rdata;
          3'd2:    head_s    <= rdata;
          3'd3:    head_f    <= rdata;
          3'd4:    head_mode <= rdata;
          default: ;
        endcase
      end
      if (done && (state == ST_RD_STAT) && (step == 3'd1)) stat0 <= rdata;
    end
  end

endmodule

// File: tb/tb_cdc_host_seq.sv
// Directed bench for cdc_host_seq with a behavioural CD host chip (auto-increment register file, IRQ sources).
module tb_cdc_host_seq;

  logic        clk = 1'b0;
  logic        nRESET = 1'b0;
  logic        enable = 1'b0;
  logic [11:0] xfer_len = 12'h000;
  logic [7:0]  head_m;
  logic [7:0]  head_s;
  logic [7:0]  head_f;
  logic [7:0]  head_mode;
  logic [7:0]  stat0;
  logic        sector_stb;
  logic        xfer_done;
  logic        busy;

  cdc_host_seq_if bus ();

  cdc_host_seq dut (
    .clk_12m    (clk),
    .nRESET     (nRESET),
    .enable     (enable),
    .xfer_len   (xfer_len),
    .bus        (bus),
    .head_m     (head_m),
    .head_s     (head_s),
    .head_f     (head_f),
    .head_mode  (head_mode),
    .stat0      (stat0),
    .sector_stb (sector_stb),
    .xfer_done  (xfer_done),
    .busy       (busy)
  );

  always #42 clk = ~clk;

  // Target model: interrupt sources are request/clear counter pairs so each has one writer
  int dec_req = 0, dec_clr = 0, dte_req = 0, dte_clr = 0, spur_req = 0, spur_clr = 0;
  logic dec_irq, dte_irq, spur_irq;
  logic [7:0] regs [0:15];
  logic [3:0] ptr = 4'd0;
  logic [7:0] ifstat;

  assign dec_irq   = (dec_req != dec_clr);
  assign dte_irq   = (dte_req != dte_clr);
  assign spur_irq  = (spur_req != spur_clr);
  assign ifstat    = ~{1'b0, dte_irq, dec_irq, 5'b00000};
  assign bus.nirq  = ~(dec_irq | dte_irq | spur_irq);
  assign bus.rdata = (ptr == 4'd1) ? ifstat : regs[ptr];

  logic [9:0] acc_log [$];
  int   low_cnt = 0, bad_strobe = 0, n_stb = 0, n_done = 0;
  logic cur_we = 1'b0;

  always @(negedge clk) begin
    if (!nRESET) begin
      low_cnt = 0;
    end else if (!bus.nwr || !bus.nrd) begin
      if (!bus.nwr && !bus.nrd) bad_strobe++;
      low_cnt++;
      cur_we = !bus.nwr;
      if (low_cnt == 1 && bus.rs) begin
        if (!bus.nrd && ptr == 4'd1 && spur_irq) spur_clr++;
        if (!bus.nrd && ptr == 4'd15 && dec_irq) dec_clr++;
        if (!bus.nwr && ptr == 4'd7 && dte_irq) dte_clr++;
      end
    end else if (low_cnt > 0) begin
      if (low_cnt != 3) bad_strobe++;
      acc_log.push_back({cur_we, bus.rs, cur_we ? bus.wdata : bus.rdata});
      if (!bus.rs && cur_we) ptr = bus.wdata[3:0];
      else if (bus.rs)       ptr = ptr + 4'd1;
      low_cnt = 0;
    end
    if (sector_stb) n_stb++;
    if (xfer_done)  n_done++;
  end

  int n_chk = 0, n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [9:0] wa(input logic [7:0] a); return {2'b10, a}; endfunction
  function automatic logic [9:0] wd(input logic [7:0] d); return {2'b11, d}; endfunction
  function automatic logic [9:0] rd(input logic [7:0] d); return {2'b01, d}; endfunction

  int rd_idx = 0;
  logic [9:0] exp_q [$];

  task automatic expect_acc(input string tag, input logic [9:0] exp);
    int t = 0;
    while (acc_log.size() <= rd_idx && t < 2000) begin
      @(negedge clk);
      t++;
    end
    if (acc_log.size() <= rd_idx) begin
      chk({tag, "_timeout"}, 32'hDEAD, 32'(exp));
    end else begin
      chk(tag, 32'(acc_log[rd_idx]), 32'(exp));
      rd_idx++;
    end
  endtask

  task automatic drain(input string tag);
    for (int i = 0; i < exp_q.size(); i++) expect_acc($sformatf("%s[%0d]", tag, i), exp_q[i]);
    exp_q.delete();
  endtask

  task automatic quiet(input string tag, input int cycles);
    int n0 = acc_log.size();
    repeat (cycles) @(negedge clk);
    chk(tag, 32'(acc_log.size()), 32'(n0));
  endtask

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int t;
    for (int i = 0; i < 16; i++) regs[i] = 8'h00;
    regs[4] = 8'h00; regs[5] = 8'h02; regs[6] = 8'h16; regs[7] = 8'h01;
    regs[12] = 8'h80; regs[13] = 8'h11; regs[14] = 8'h22; regs[15] = 8'h33;

    // Reset values
    repeat (3) @(negedge clk);
    chk("rst_nwr", 32'(bus.nwr), 32'd1);
    chk("rst_nrd", 32'(bus.nrd), 32'd1);
    chk("rst_rs_wdata", 32'({bus.rs, bus.wdata}), 32'd0);
    chk("rst_head", {head_m, head_s, head_f, head_mode}, 32'd0);
    chk("rst_stat0", 32'(stat0), 32'd0);
    chk("rst_pulses_busy", 32'({sector_stb, xfer_done, busy}), 32'd0);
    nRESET = 1'b1;
    quiet("idle_quiet", 10);

    // Init sequence
    enable = 1'b1;
    exp_q = '{wa(8'h01), wd(8'h60), wa(8'h0A), wd(8'h80)};
    drain("init");
    quiet("wait_irq_quiet", 20);
    chk("busy_wait", 32'(busy), 32'd1);

    // Decoder IRQ: header/status capture then programming; length change after reg2 must not leak
    xfer_len = 12'h7FF;
    dec_req++;
    exp_q = '{wa(8'h01), rd(8'hDF), wa(8'h04), rd(8'h00), rd(8'h02), rd(8'h16), rd(8'h01),
              wa(8'h0C), rd(8'h80), rd(8'h11), rd(8'h22), rd(8'h33), wa(8'h02), wd(8'hFF)};
    drain("sector1");
    xfer_len = 12'h123;
    exp_q = '{wd(8'h07), wd(8'h00), wd(8'h00), wd(8'h00)};
    drain("prog1");
    quiet("wait_dte_quiet", 20);
    chk("head1", {head_m, head_s, head_f, head_mode}, 32'h00021601);
    chk("stat0_1", 32'(stat0), 32'h80);
    chk("stb_count1", 32'(n_stb), 32'd1);

    // Transfer end
    dte_req++;
    exp_q = '{wa(8'h01), rd(8'hBF), wa(8'h07), wd(8'h00)};
    drain("ack1");
    quiet("after_ack_quiet", 20);
    chk("done_count1", 32'(n_done), 32'd1);
    chk("stb_count_ack", 32'(n_stb), 32'd1);

    // Spurious IRQ: IFSTAT=FF, no write
    spur_req++;
    exp_q = '{wa(8'h01), rd(8'hFF)};
    drain("spur");
    quiet("spur_quiet", 30);
    chk("done_count_spur", 32'(n_done), 32'd1);

    // Both pending: header path first, then ACK at next IRQ check
    regs[4] = 8'h12; regs[5] = 8'h34; regs[6] = 8'h56; regs[7] = 8'h02; regs[12] = 8'h01;
    dec_req++;
    dte_req++;
    exp_q = '{wa(8'h01), rd(8'h9F), wa(8'h04), rd(8'h12), rd(8'h34), rd(8'h56), rd(8'h02),
              wa(8'h0C), rd(8'h01), rd(8'h11), rd(8'h22), rd(8'h33),
              wa(8'h02), wd(8'h23), wd(8'h01), wd(8'h00), wd(8'h00), wd(8'h00),
              wa(8'h01), rd(8'hBF), wa(8'h07), wd(8'h00)};
    drain("both");
    quiet("both_quiet", 20);
    chk("head2", {head_m, head_s, head_f, head_mode}, 32'h12345602);
    chk("stat0_2", 32'(stat0), 32'h01);
    chk("counts2", 32'({n_stb[7:0], n_done[7:0]}), 32'h0202);

    // ENABLE dropped at T2 of the HEAD_M read
    regs[4] = 8'hA5;
    dec_req++;
    exp_q = '{wa(8'h01), rd(8'hDF), wa(8'h04)};
    drain("drop");
    t = 0;
    while (bus.nrd && t < 200) begin @(negedge clk); t++; end
    chk("drop_t1_seen", 32'(bus.nrd), 32'd0);
    @(negedge clk);
    enable = 1'b0;
    expect_acc("drop_read", rd(8'hA5));
    quiet("drop_quiet", 30);
    chk("drop_busy", 32'(busy), 32'd0);
    chk("drop_head", {head_m, head_s}, 32'h0000A534);

    // Reset pulse at T2 of the first INIT write
    enable = 1'b1;
    t = 0;
    while (bus.nwr && t < 200) begin @(negedge clk); t++; end
    chk("rst_t1_seen", 32'(bus.nwr), 32'd0);
    @(negedge clk);
    nRESET = 1'b0;
    enable = 1'b0;
    #1;
    chk("arst_strobes", 32'({bus.nwr, bus.nrd}), 32'd3);
    chk("arst_rs_wdata", 32'({bus.rs, bus.wdata}), 32'd0);
    chk("arst_head", {head_m, head_s, head_f, head_mode}, 32'd0);
    chk("arst_stat_busy", 32'({stat0, sector_stb, xfer_done, busy}), 32'd0);
    @(negedge clk);
    nRESET = 1'b1;
    quiet("post_reset_quiet", 20);
    chk("strobe_len", 32'(bad_strobe), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
